// File: rtl/gray_lbp_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_lbp_mem: gray image store and LBP result store; load/serve/unload.  |
// | Optional macro LBP_WR_CHECK_EN adds wr_cnt/wr_err ports.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module gray_lbp_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        gray_ready,
  input  logic        gray_req,
  input  logic [13:0] gray_addr,
  output logic [7:0]  gray_data,
  input  logic        lbp_valid,
  input  logic [13:0] lbp_addr,
  input  logic [7:0]  lbp_data,
  input  logic        finish,
  output logic        ul_valid,
  output logic [7:0]  ul_data,
  output logic        ul_last,
  input  logic        ul_ready,
`ifdef LBP_WR_CHECK_EN
  output logic [14:0] wr_cnt,
  output logic        wr_err,
`endif
  output logic        done
);

  localparam logic [13:0] LAST_PTR = 14'h3FFF;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SERVE  = 2'd1,
    UNLOAD = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [13:0] ld_ptr;
  logic [13:0] ul_ptr;
  logic        ld_fire;
  logic        ul_fire;
  logic        lbp_wr;

  logic [7:0]  gray_mem   [16384];
  logic [7:0]  result_mem [16384];

  assign ld_fire = ld_valid && ld_ready;
  assign ul_fire = ul_valid && ul_ready;
  assign lbp_wr  = (state == SERVE) && lbp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= LOAD;
      ld_ptr <= 14'd0;
      ul_ptr <= 14'd0;
    end else begin
      state <= state_nxt;
      // Pointers stop at the last entry; the state change ends each phase.
      if (ld_fire && (ld_ptr != LAST_PTR)) ld_ptr <= ld_ptr + 14'd1;
      if (ul_fire && (ul_ptr != LAST_PTR)) ul_ptr <= ul_ptr + 14'd1;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_fire) gray_mem[ld_ptr] <= ld_data;
    if (lbp_wr)  result_mem[lbp_addr] <= lbp_data;
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    gray_ready = 1'b0;
    gray_data  = 8'd0;
    ul_valid   = 1'b0;
    ul_data    = 8'd0;
    ul_last    = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = reset;
        if (ld_valid && reset && (ld_ptr == LAST_PTR)) state_nxt = SERVE;
      end
      SERVE: begin
        gray_ready = 1'b1;
        if (gray_req) gray_data = gray_mem[gray_addr];
        if (finish) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        ul_valid = 1'b1;
        ul_data  = result_mem[ul_ptr];
        ul_last  = (ul_ptr == LAST_PTR);
        if (ul_ready && (ul_ptr == LAST_PTR)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

`ifdef LBP_WR_CHECK_EN
  logic [14:0] wr_cnt_nxt;

  assign wr_cnt_nxt = (lbp_wr && (wr_cnt != 15'h7FFF)) ? wr_cnt + 15'd1 : wr_cnt;

  // A write in the finish cycle is included in the count that is judged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt <= 15'd0;
      wr_err <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_nxt;
      if ((state == SERVE) && finish && (wr_cnt_nxt != 15'd16384)) wr_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_lbp_mem.sv
`default_nettype none
// Self-checking bench for gray_lbp_mem: scoreboarded reads and unload stream,
// abort by reset mid-unload, reload and full stalled unload.
module tb_gray_lbp_mem;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        ul_valid;
  logic [7:0]  ul_data;
  logic        ul_last;
  logic        ul_ready;
  logic        done;
`ifdef LBP_WR_CHECK_EN
  logic [14:0] wr_cnt;
  logic        wr_err;
`endif

  gray_lbp_mem dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .ul_valid   (ul_valid),
    .ul_data    (ul_data),
    .ul_last    (ul_last),
    .ul_ready   (ul_ready),
`ifdef LBP_WR_CHECK_EN
    .wr_cnt     (wr_cnt),
    .wr_err     (wr_err),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  gray_model [16384];
  logic [7:0]  res_model  [16384];
  logic [7:0]  exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int sel, input logic [13:0] a);
    if (sel == 1) return a[7:0];
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] wdat(input logic [13:0] a);
    logic [13:0] t;
    t = a * 14'd7 + 14'd3;
    return t[7:0];
  endfunction

  // Full image load; optionally drives SERVE-only controls in the first cycle.
  task automatic load_image(input int sel, input bit poke_ignored);
    for (int i = 0; i < 16384; i++) begin
      logic [13:0] a;
      a = i[13:0];
      ld_valid = 1'b1;
      ld_data  = pat(sel, a);
      gray_model[i] = pat(sel, a);
      if (poke_ignored && i == 0) begin
        lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'h11; finish = 1'b1;
        gray_req = 1'b1; gray_addr = 14'd0;
        #1 check_eq("load_gray_data_zero", gray_data, 8'h00);
      end
      if (i == 0 || i == 16383) check_eq("load_ld_ready", ld_ready, 1'b1);
      tick();
      lbp_valid = 1'b0; finish = 1'b0; gray_req = 1'b0;
    end
    ld_valid = 1'b0;
    check_eq("load_end_ld_ready", ld_ready, 1'b0);
    check_eq("load_end_gray_ready", gray_ready, 1'b1);
  endtask

  task automatic serve_reads(input int n);
    for (int k = 0; k < n; k++) begin
      logic [13:0] a;
      a = (k == 0) ? 14'h0081 : 14'($urandom_range(0, 16383));
      gray_req  = 1'b1;
      gray_addr = a;
      exp_q.push_back(gray_model[a]);
      #2;
      if (exp_q.size() > 0) check_eq("gray_read", gray_data, exp_q.pop_front());
      tick();
    end
    gray_req  = 1'b0;
    gray_addr = 14'h0081;
    exp_q.push_back(8'h00);
    #2;
    if (exp_q.size() > 0) check_eq("gray_req_low", gray_data, exp_q.pop_front());
    tick();
  endtask

  task automatic queue_results();
    exp_q.delete();
    for (int i = 0; i < 16384; i++) exp_q.push_back(res_model[i]);
  endtask

  initial begin
    int          beat;
    int          cyc;
    logic        held_v;
    logic [8:0]  held;
    logic [7:0]  e;

    reset = 1'b0; ld_valid = 1'b0; ld_data = 8'd0; gray_req = 1'b0; gray_addr = 14'd0;
    lbp_valid = 1'b0; lbp_addr = 14'd0; lbp_data = 8'd0; finish = 1'b0; ul_ready = 1'b0;

    #3;
    check_eq("rst_ld_ready", ld_ready, 1'b0);
    check_eq("rst_gray_ready", gray_ready, 1'b0);
    check_eq("rst_ul_valid", ul_valid, 1'b0);
    check_eq("rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_eq("rel_ld_ready", ld_ready, 1'b1);
`ifdef LBP_WR_CHECK_EN
    check_eq("rst_wr_cnt", wr_cnt, 15'd0);
    check_eq("rst_wr_err", wr_err, 1'b0);
`endif
    tick();

    // Run 1: ramp image, all results written, last write coincident with finish.
    load_image(1, 1'b0);
    serve_reads(30);
    for (int i = 0; i < 16384; i++) begin
      logic [13:0] a;
      a = i[13:0];
      if (i != 5) begin
        lbp_valid = 1'b1; lbp_addr = a; lbp_data = wdat(a);
        res_model[i] = wdat(a);
        tick();
      end
    end
    lbp_addr = 14'd5; lbp_data = 8'hA5; finish = 1'b1; res_model[5] = 8'hA5;
    tick();
    lbp_valid = 1'b0; finish = 1'b0;
    check_eq("unload_entered", ul_valid, 1'b1);
`ifdef LBP_WR_CHECK_EN
    check_eq("wr_cnt_full", wr_cnt, 15'd16384);
    check_eq("wr_err_full", wr_err, 1'b0);
`endif

    // Unload until beat 100, then abort by reset.
    queue_results();
    beat = 0; cyc = 0;
    ul_ready = 1'b1;
    while (beat < 100 && cyc < 1000) begin
      #2;
      if (ul_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("abort_run_data", ul_data, e);
        if (beat == 5) check_eq("beat5_a5", ul_data, 8'hA5);
        beat++;
      end
      tick();
      cyc++;
    end
    check_eq("abort_run_beats", beat, 100);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_ul_valid", ul_valid, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_ld_ready", ld_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_rel_ld_ready", ld_ready, 1'b1);
    check_eq("abort_rel_ul_valid", ul_valid, 1'b0);
    check_eq("abort_rel_gray_ready", gray_ready, 1'b0);
    ul_ready = 1'b0;
    exp_q.delete();
    tick();

    // Run 2: reload different image; results from run 1 are retained.
    load_image(2, 1'b1);
    serve_reads(40);
    lbp_valid = 1'b1; lbp_addr = 14'd10; lbp_data = 8'h99; tick();
    lbp_data = 8'h3C; res_model[10] = 8'h3C; tick();
    lbp_valid = 1'b0; finish = 1'b1; tick();
    finish = 1'b0;
`ifdef LBP_WR_CHECK_EN
    check_eq("wr_cnt_short", wr_cnt, 15'd2);
    check_eq("wr_err_short", wr_err, 1'b1);
`endif

    queue_results();
    beat = 0; cyc = 0; held_v = 1'b0; held = 9'd0;
    while (beat < 16384 && cyc < 40000) begin
      ul_ready = (cyc < 512) ? ~cyc[0] : ((cyc % 8) != 7);
      #2;
      if (held_v) check_eq("ul_hold", {ul_last, ul_data}, held);
      held_v = 1'b0;
      if (ul_valid) begin
        if (ul_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("ul_data", ul_data, e);
          end
          if (beat == 5) check_eq("beat5_retained", ul_data, 8'hA5);
          if (beat == 10) check_eq("beat10_overwrite", ul_data, 8'h3C);
          if (ul_last || beat == 16383) check_eq("ul_last", ul_last, beat == 16383);
          beat++;
        end else begin
          held   = {ul_last, ul_data};
          held_v = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    ul_ready = 1'b0;
    check_eq("ul_beats", beat, 16384);
    check_eq("done_set", done, 1'b1);
    check_eq("done_ul_valid", ul_valid, 1'b0);
    check_eq("done_ld_ready", ld_ready, 1'b0);
    check_eq("done_gray_ready", gray_ready, 1'b0);
    ul_ready = 1'b1; ld_valid = 1'b1; finish = 1'b1;
    repeat (3) tick();
    check_eq("done_held", done, 1'b1);
    check_eq("done_held_ul_valid", ul_valid, 1'b0);
    ul_ready = 1'b0; ld_valid = 1'b0; finish = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
